// File: rtl/matrix_result_writer.sv
// ---------------------------------------------------------------------------
// matrix_result_writer
//
// Consumer end of the matrix-multiply datapath. Products arrive in the order
// the operand address generator walks them: DIM products per C element,
// DIM elements per row of C (col fastest), DIM rows, DIM^3 products in all.
// Each group of DIM products is summed and written to C[DIM*row+col] as a
// single-cycle write strobe.
//
// Handshake: in_valid is a one-cycle strobe with no back-pressure; a product
// is accepted on a rising edge where in_valid=1, the FSM is in RUN and
// start=0. we is a one-cycle strobe; waddr/wdata are valid while we=1 and
// hold their last written values otherwise.
//
// Ports:
//   clk       in   1     clock, rising edge
//   rst       in   1     synchronous active-high reset
//   start     in   1     one-cycle pulse: clear counters/acc/err, enter RUN
//   in_valid  in   1     product strobe
//   prod      in   PW    unsigned product
//   we        out  1     result write enable (one cycle per C element)
//   waddr     out  AW    result address DIM*row+col
//   wdata     out  ACCW  accumulated dot product
//   busy      out  1     high in RUN
//   done      out  1     high in DONE until next start or rst
//   err       out  1     sticky: in_valid seen outside RUN
//   fsm_state out  2     current FSM state (0 IDLE, 1 RUN, 2 DONE)
// ---------------------------------------------------------------------------
module matrix_result_writer #(
    parameter int DIM  = 3,
    parameter int PW   = 16,
    parameter int AW   = $clog2(DIM * DIM),
    parameter int ACCW = PW + $clog2(DIM)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    input  logic [PW-1:0]   prod,
    output logic            we,
    output logic [AW-1:0]   waddr,
    output logic [ACCW-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [1:0]      fsm_state
);

    // Counter width: DIM >= 2 so this is at least one bit.
    localparam int CW = $clog2(DIM);
    localparam logic [CW-1:0] LAST = CW'(DIM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state,      state_next;
    logic [CW-1:0]   k,          k_next;
    logic [CW-1:0]   col,        col_next;
    logic [CW-1:0]   row,        row_next;
    logic [ACCW-1:0] acc,        acc_next;
    logic            we_next;
    logic [AW-1:0]   waddr_next;
    logic [ACCW-1:0] wdata_next;
    logic            err_next;

    logic [ACCW-1:0] sum;
    logic [AW-1:0]   addr_calc;

    // Product is zero-extended; ACCW is sized so DIM*(2^PW-1) fits.
    assign sum       = acc + ACCW'(prod);
    assign addr_calc = AW'(DIM) * AW'(row) + AW'(col);

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        k_next     = k;
        col_next   = col;
        row_next   = row;
        acc_next   = acc;
        we_next    = 1'b0;
        waddr_next = waddr;
        wdata_next = wdata;
        err_next   = err;

        if (start) begin
            // start wins over a coincident in_valid: product dropped, no err.
            state_next = RUN;
            k_next     = '0;
            col_next   = '0;
            row_next   = '0;
            acc_next   = '0;
            err_next   = 1'b0;
        end else if (in_valid) begin
            if (state != RUN) begin
                err_next = 1'b1;
            end else if (k != LAST) begin
                acc_next = sum;
                k_next   = k + CW'(1);
            end else begin
                // Group complete: emit the element and restart accumulation
                // so a product in the very next cycle begins a fresh group.
                we_next    = 1'b1;
                waddr_next = addr_calc;
                wdata_next = sum;
                acc_next   = '0;
                k_next     = '0;
                if (col != LAST) begin
                    col_next = col + CW'(1);
                end else begin
                    col_next = '0;
                    if (row != LAST) begin
                        row_next = row + CW'(1);
                    end else begin
                        row_next   = '0;
                        state_next = DONE;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            col   <= '0;
            row   <= '0;
            acc   <= '0;
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            k     <= k_next;
            col   <= col_next;
            row   <= row_next;
            acc   <= acc_next;
            we    <= we_next;
            waddr <= waddr_next;
            wdata <= wdata_next;
            err   <= err_next;
        end
    end

    // Status decoded from the registered state, so done/busy change on the
    // same edge that raises the final we.
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_matrix_result_writer.sv
// ---------------------------------------------------------------------------
// tb_matrix_result_writer
//
// Directed bench for matrix_result_writer (DIM=3, PW=16). The driver pushes
// one expected write {last, addr, data, cycle} per completed group into
// exp_q; a monitor pops and compares on every we strobe. Status outputs are
// checked directly by the main sequence.
// ---------------------------------------------------------------------------
module tb_matrix_result_writer;

  localparam int DIM   = 3;
  localparam int PW    = 16;
  localparam int AW    = 4;
  localparam int ACCW  = 18;
  localparam int NPROD = DIM * DIM * DIM;
  localparam int W     = 1 + AW + ACCW + 32;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            in_valid = 1'b0;
  logic [PW-1:0]   prod = '0;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [ACCW-1:0] wdata;
  logic            busy;
  logic            done;
  logic            err;
  logic [1:0]      fsm_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  matrix_result_writer #(
    .DIM  (DIM),
    .PW   (PW),
    .AW   (AW),
    .ACCW (ACCW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .prod      (prod),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .fsm_state (fsm_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;
  logic [PW-1:0] prods[NPROD];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic monitor();
    logic [W-1:0]    e;
    logic            e_last;
    logic [AW-1:0]   e_addr;
    logic [ACCW-1:0] e_data;
    logic [31:0]     e_cyc;
    forever begin
      @(negedge clk);
      if (we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", 64'(waddr), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          {e_last, e_addr, e_data, e_cyc} = e;
          check("waddr", 64'(waddr), 64'(e_addr));
          check("wdata", 64'(wdata), 64'(e_data));
          check("we_cycle", 64'(cyc), 64'(e_cyc));
          check("done_at_write", 64'(done), 64'(e_last));
          check("busy_at_write", 64'(busy), 64'(!e_last));
        end
      end
    end
  endtask

  // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends prods[0..n-1]; pushes one expected write per completed group.
  task automatic send_seq(input int n, input int max_gap);
    logic [ACCW-1:0] sum;
    sum = '0;
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      in_valid = 1'b1;
      prod     = prods[i];
      sum      = sum + ACCW'(prods[i]);
      if (i % DIM == DIM - 1) begin
        exp_q.push_back({(i == NPROD - 1), AW'(i / DIM), sum, 32'(cyc + 1)});
        sum = '0;
      end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic fill_const(input logic [PW-1:0] v);
    for (int i = 0; i < NPROD; i++) prods[i] = v;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < NPROD; i++) prods[i] = PW'(i + 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [AW-1:0]   saved_addr;
    logic [ACCW-1:0] saved_data;
    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    check("rst_we", 64'(we), 64'd0);
    check("rst_waddr", 64'(waddr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_state", 64'(fsm_state), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // in_valid while IDLE: flagged, no write
    in_valid = 1'b1; prod = 16'h1234;
    @(negedge clk);
    in_valid = 1'b0;
    check("idle_err", 64'(err), 64'd1);
    check("idle_waddr", 64'(waddr), 64'd0);
    check("idle_wdata", 64'(wdata), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);

    pulse_start();
    check("start_err_clr", 64'(err), 64'd0);
    check("start_busy", 64'(busy), 64'd1);
    check("start_state", 64'(fsm_state), 64'd1);

    // All ones, back-to-back: wdata=3 at addr 0..8
    fill_const(16'd1);
    send_seq(NPROD, 0);
    check("run1_done", 64'(done), 64'd1);
    check("run1_busy", 64'(busy), 64'd0);
    check("run1_state", 64'(fsm_state), 64'd2);

    // in_valid while DONE: flagged, outputs held
    @(negedge clk);
    saved_addr = 4'd8;
    saved_data = 18'd3;
    in_valid = 1'b1; prod = 16'h00FF;
    @(negedge clk);
    in_valid = 1'b0;
    check("done_err", 64'(err), 64'd1);
    check("done_we", 64'(we), 64'd0);
    check("done_waddr_hold", 64'(waddr), 64'(saved_addr));
    check("done_wdata_hold", 64'(wdata), 64'(saved_data));
    check("done_still", 64'(done), 64'd1);

    pulse_start();
    check("restart_err_clr", 64'(err), 64'd0);
    check("restart_busy", 64'(busy), 64'd1);
    check("restart_done_clr", 64'(done), 64'd0);

    // Ramp 1..27: 6, 15, 24, ..., 78
    fill_ramp();
    send_seq(NPROD, 0);

    // Max products: 3*0xFFFF = 0x2FFFD, no wrap
    pulse_start();
    fill_const(16'hFFFF);
    send_seq(NPROD, 0);

    // Ramp again with random gaps 0..5: same addresses/data
    pulse_start();
    fill_ramp();
    send_seq(NPROD, 5);

    // Mid-run start, coincident with the group-completing product
    pulse_start();
    fill_const(16'd1);
    send_seq(14, 0);
    start = 1'b1; in_valid = 1'b1; prod = 16'd1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    check("midstart_err", 64'(err), 64'd0);
    check("midstart_busy", 64'(busy), 64'd1);
    check("midstart_we", 64'(we), 64'd0);
    fill_const(16'd2);
    send_seq(NPROD, 0);

    // Mid-run reset, coincident with the group-completing product
    pulse_start();
    fill_const(16'd1);
    send_seq(14, 0);
    rst = 1'b1; in_valid = 1'b1; prod = 16'd1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check("midrst_we", 64'(we), 64'd0);
    check("midrst_waddr", 64'(waddr), 64'd0);
    check("midrst_wdata", 64'(wdata), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_err", 64'(err), 64'd0);
    check("midrst_state", 64'(fsm_state), 64'd0);

    repeat (5) @(negedge clk);
    check("drain_exp_q", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog: the sequence above is a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
